// File: rtl/seq_tail_light_ctrl_if.sv
// Lamp-controller signal bundle: vehicle requests in, lamp drive and debug phase out.
interface seq_tail_light_ctrl_if #(
  parameter int LAMPS = 3
);
  localparam int PW = $clog2(LAMPS + 1);

  logic             brake;
  logic             turn_right;
  logic             turn_left;
  logic             hazard;
  logic [LAMPS-1:0] right_tail_light_control;
  logic [LAMPS-1:0] left_tail_light_control;
  logic [PW-1:0]    seq_phase;

  modport master (
    output brake, turn_right, turn_left, hazard,
    input  right_tail_light_control, left_tail_light_control, seq_phase
  );

  modport slave (
    input  brake, turn_right, turn_left, hazard,
    output right_tail_light_control, left_tail_light_control, seq_phase
  );
endinterface

// File: rtl/seq_tail_light_ctrl.sv
// Sequential tail-light controller: thermometer sweep per side, hazard lockstep,
// brake-aware pattern mixing, programmable step rate. All outputs registered.
//
// state | meaning
// IDLE  | no turn/hazard request; lamps follow brake only
// SEQ_R | right sweep; left side follows brake
// SEQ_L | left sweep; right side follows brake
// HAZ   | both sides sweep in phase lock
module seq_tail_light_ctrl #(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_tail_light_ctrl_if.slave tl
);

  localparam int PW = $clog2(LAMPS + 1);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ_R = 2'd1,
    SEQ_L = 2'd2,
    HAZ   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [DW-1:0]    div_q, div_d;
  logic [LAMPS-1:0] right_q, right_d;
  logic [LAMPS-1:0] left_q, left_d;
  logic [LAMPS-1:0] pat;
  logic [LAMPS-1:0] pat_mix;
  logic [LAMPS-1:0] steady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      div_q   <= '0;
      right_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      right_q <= right_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (tl.hazard || (tl.turn_left && tl.turn_right)) state_d = HAZ;
    else if (tl.turn_right)                           state_d = SEQ_R;
    else if (tl.turn_left)                            state_d = SEQ_L;
  end

  // Any state change (including a direction swap) restarts the sweep at phase 0.
  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    if (state_d == IDLE || state_d != state_q) begin
      phase_d = '0;
      div_d   = '0;
    end else if (div_q == DW'(STEP_DIV - 1)) begin
      div_d   = '0;
      phase_d = (phase_q == PW'(LAMPS)) ? '0 : phase_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Thermometer pattern for the upcoming phase; phase LAMPS is the dark gap.
  always_comb begin
    pat = '0;
    for (int i = 0; i < LAMPS; i++) begin
      pat[i] = (phase_d < PW'(LAMPS)) && (PW'(i) <= phase_d);
    end
  end

  always_comb begin
    pat_mix = tl.brake ? ~pat : pat;
    steady  = tl.brake ? '1 : '0;
    right_d = steady;
    left_d  = steady;
    case (state_d)
      SEQ_R:   right_d = pat_mix;
      SEQ_L:   left_d  = pat_mix;
      HAZ: begin
        right_d = pat_mix;
        left_d  = pat_mix;
      end
      default: ;
    endcase
  end

  assign tl.right_tail_light_control = right_q;
  assign tl.left_tail_light_control  = left_q;
  assign tl.seq_phase                = phase_q;

endmodule

// File: tb/tb_seq_tail_light_ctrl.sv
// Directed bench: LAMPS=3 with STEP_DIV=1 (main DUT) and STEP_DIV=4 (rate DUT).
module tb_seq_tail_light_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_tail_light_ctrl_if #(.LAMPS(3)) tl1 ();
  seq_tail_light_ctrl_if #(.LAMPS(3)) tl4 ();

  seq_tail_light_ctrl #(.LAMPS(3), .STEP_DIV(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tl    (tl1.slave)
  );

  seq_tail_light_ctrl #(.LAMPS(3), .STEP_DIV(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .tl    (tl4.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // expected {right,left} and phase for the main DUT
  task automatic chk1(input string tag, input logic [2:0] r, input logic [2:0] l,
                      input logic [1:0] ph);
    chk({tag, " lamps"}, {2'b00, tl1.right_tail_light_control, tl1.left_tail_light_control},
        {2'b00, r, l});
    chk({tag, " phase"}, {6'd0, tl1.seq_phase}, {6'd0, ph});
  endtask

  task automatic set1(input logic b, input logic r, input logic l, input logic h);
    tl1.brake      = b;
    tl1.turn_right = r;
    tl1.turn_left  = l;
    tl1.hazard     = h;
  endtask

  initial begin
    logic [2:0] sweep [4];
    sweep[0] = 3'b001; sweep[1] = 3'b011; sweep[2] = 3'b111; sweep[3] = 3'b000;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    tl4.brake = 1'b0; tl4.turn_right = 1'b0; tl4.turn_left = 1'b0; tl4.hazard = 1'b0;
    #12;
    chk1("reset", 3'b000, 3'b000, 2'd0);

    // right sweep from reset release
    set1(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1($sformatf("right_sweep%0d", k), sweep[k % 4], 3'b000, 2'(k % 4));
    end

    // at right=011, swap to left
    set1(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk1("dir_swap", 3'b000, 3'b001, 2'd0);
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("release_idle", 3'b000, 3'b000, 2'd0);

    // brake + left sweep shows complement, right all-on
    set1(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1($sformatf("brake_left%0d", k), 3'b111, ~sweep[k % 4], 2'(k % 4));
    end
    set1(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("brake_only", 3'b111, 3'b111, 2'd0);

    // hazard lockstep
    set1(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1($sformatf("hazard%0d", k), sweep[k % 4], sweep[k % 4], 2'(k % 4));
    end
    // brake mid-hazard: complement, phase keeps advancing
    set1(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk1("hazard_brake", 3'b100, 3'b100, 2'd1);
    // both turns decode to hazard too: same state, no restart
    set1(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk1("both_turns2", 3'b111, 3'b111, 2'd2);
    tick();
    chk1("both_turns3", 3'b000, 3'b000, 2'd3);
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk1("both_turns_brake", 3'b110, 3'b110, 2'd0);

    // async reset mid-sweep
    set1(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk1("pre_rst0", 3'b001, 3'b000, 2'd0);
    tick();
    chk1("pre_rst1", 3'b011, 3'b000, 2'd1);
    #3 rst_n = 1'b0;
    #1;
    chk1("async_rst", 3'b000, 3'b000, 2'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk1("post_rst", 3'b001, 3'b000, 2'd0);
    set1(1'b0, 1'b0, 1'b0, 1'b0);

    // STEP_DIV=4: each pattern holds 4 clocks, 16-clock sweep
    tl4.turn_right = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk($sformatf("div4_%0d", k),
          {2'b00, tl4.right_tail_light_control, tl4.left_tail_light_control},
          {2'b00, sweep[(k / 4) % 4], 3'b000});
    end
    tl4.turn_right = 1'b0;
    tick();
    chk("div4_idle", {6'd0, tl4.seq_phase}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
